mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of BUSY cycles spent waiting for bus_ack.
REQ-002 The block SHALL have ports, clock and reset first:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  the decoded instruction is valid this cycle.
- rwmem  in  1  the instruction accesses memory.
- memWE  in  1  1 = store, 0 = load.
- byteena  in  4  store byte mask from the decoder: 0001 SB, 0011 SH, 1111 SW, 0000 invalid.
- funct3  in  3  load width and sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr  in  32  effective byte address.
- wdata  in  32  store data, right-aligned.
- stall  out  1  hold the PC and pipeline.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualified by done; the access faulted.
- rdata  out  32  extended load result, qualified by done.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word-aligned bus address.
- bus_be  out  4  bus byte lanes.
- bus_wdata  out  32  lane-shifted store data.
- bus_ack  in  1  bus completion.
- bus_rdata  in  32  bus read data, valid with bus_ack.

Function
REQ-003 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-004 In IDLE with req_valid=1 and rwmem=1, the block SHALL latch memWE, funct3, byteena, addr and wdata, and SHALL assert stall combinationally in that same cycle.
REQ-005 An access SHALL be misaligned when any of these hold: halfword with addr[0]=1; word with addr[1:0]!=00; store with byteena=0000; load with funct3 outside the five legal codes.
- On a misaligned access, IDLE SHALL go to DONE with err=1.
- On a misaligned access, bus_req SHALL never be asserted.
REQ-006 On an aligned access, IDLE SHALL go to BUSY.
REQ-007 In BUSY, bus_req SHALL be 1 and the bus outputs SHALL be held stable until the cycle in which bus_ack=1.
REQ-008 In BUSY, bus_addr SHALL be {addr[31:2],2'b00}.
- For a store, bus_be SHALL be byteena<<addr[1:0].
- For a load, bus_be SHALL be the width mask (0001, 0011 or 1111) shifted left by addr[1:0].
REQ-009 In BUSY, bus_wdata SHALL be wdata<<(8*addr[1:0]) and bus_we SHALL equal the latched memWE.
REQ-010 When bus_ack=1 in BUSY, the block SHALL go to DONE.
- On a load, it SHALL also capture bus_rdata>>(8*addr[1:0]).
- The captured value SHALL be sign-extended for LB and LH, zero-extended for LBU and LHU, and passed unchanged for LW.
REQ-011 BUSY SHALL count its cycles.
- If the count reaches TIMEOUT with no bus_ack, the block SHALL go to DONE with err=1 and SHALL deassert bus_req.
- A bus_ack in the same cycle as the timeout SHALL win, with err=0.
REQ-012 In DONE, the block SHALL drive done=1 and stall=0 for exactly one cycle, then return to IDLE.
- rdata SHALL hold its value until the next load completes.
- rdata SHALL be 0 for stores and errors.
REQ-013 stall SHALL be 1 in BUSY, and SHALL be 0 in IDLE unless REQ-004 applies.
REQ-014 req_valid SHALL be ignored outside IDLE.
REQ-015 req_valid=1 with rwmem=0 SHALL have no effect.
REQ-016 An aligned access SHALL have latency 2 + (number of cycles until bus_ack) from acceptance to done.
REQ-017 A misaligned access SHALL have latency exactly 1 from acceptance to done.

Reset
REQ-018 While rst_n=0, the block SHALL asynchronously force state=IDLE, the timeout counter=0, and all outputs=0.
REQ-019 Reset asserted mid-BUSY SHALL drop bus_req immediately, with no done pulse.
- A bus_ack arriving after reset release SHALL be ignored.

Structure
REQ-020 A shared package mem_pkg SHALL hold the state enum, the funct3 load codes, the width masks and the TIMEOUT default.
REQ-021 A single combinational sub-module, load_extend, SHALL perform the lane shift and sign/zero extension.

Verification
REQ-022 The bench SHALL cover at least these directed scenarios:
- LB addr=0x1003, bus_rdata=0x80xxxxxx, ack after 2 BUSY cycles -> bus_addr=0x1000, bus_be=1000, rdata=0xFFFFFF80, done 4 cycles after acceptance.
- SH addr=0x2002, wdata=0x0000BEEF, byteena=0011 -> bus_be=1100, bus_wdata=0xBEEF0000, bus_we=1, rdata=0.
- LW addr=0x0006 -> no bus_req, done+err the next cycle, stall high for 1 cycle only.
- LHU addr=0x0004 with no bus_ack and TIMEOUT=4 -> bus_req for 4 cycles, then done+err, bus_req=0.
- rst_n pulsed low mid-BUSY -> bus_req=0 asynchronously, state IDLE, no done; a late bus_ack is ignored.
- A new req_valid while BUSY is ignored; bus_ack coincident with the timeout gives err=0.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the memory access unit: FSM state encoding, RISC-V
// load funct3 codes, byte-lane width masks, the default bus timeout, and small
// decode helpers used by both the control path and the load extender.
// -----------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    localparam int TIMEOUT_DEFAULT = 255;

    // Unaligned byte-lane mask for a load; 0000 marks an illegal funct3.
    function automatic logic [3:0] load_mask(input logic [2:0] funct3);
        case (funct3)
            F3_LB, F3_LBU: load_mask = MASK_B;
            F3_LH, F3_LHU: load_mask = MASK_H;
            F3_LW:         load_mask = MASK_W;
            default:       load_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load formatter: shifts the addressed bytes of the bus word down
// to bit 0 and sign- or zero-extends according to funct3.
//   raw_i     in  32  bus read data (word-aligned)
//   offset_i  in   2  byte offset addr[1:0]
//   funct3_i  in   3  load width / signedness
//   result_o  out 32  register-ready load value
// -----------------------------------------------------------------------------
module load_extend
    import mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    assign shifted = raw_i >> {offset_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_LB:   result_o = {{24{shifted[7]}},  shifted[7:0]};
            F3_LH:   result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   result_o = shifted;
            F3_LBU:  result_o = {24'd0, shifted[7:0]};
            F3_LHU:  result_o = {16'd0, shifted[15:0]};
            default: result_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Load/store unit between a pipeline decoder and a single-outstanding word bus.
// Accepts one access in IDLE, faults misaligned/illegal accesses without
// touching the bus, otherwise issues one bus transaction (with a BUSY-cycle
// timeout) and reports completion with a one-cycle done pulse.
//   clk, rst_n                      clock, async active-low reset
//   req_valid, rwmem, memWE         request qualifiers (memWE: 1 store, 0 load)
//   byteena, funct3, addr, wdata    store mask, load code, byte address, data
//   stall, done, err, rdata         pipeline hold, completion pulse, fault, load data
//   bus_req, bus_we, bus_addr,
//   bus_be, bus_wdata               bus request side (held stable in BUSY)
//   bus_ack, bus_rdata              bus response side
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        rwmem,
    input  logic        memWE,
    input  logic [3:0]  byteena,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic        we_q, err_q;
    logic [2:0]  funct3_q;
    logic [3:0]  mask_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    logic        accept, misalign, busy, timeout_hit;
    logic [3:0]  acc_mask;
    logic [31:0] load_val;

    assign accept = (state_q == IDLE) && req_valid && rwmem;
    assign busy   = (state_q == BUSY);

    // Unshifted lane mask of the incoming access: stores use the decoder mask,
    // loads derive it from funct3 (0000 flags an illegal code).
    assign acc_mask = memWE ? byteena : load_mask(funct3);

    assign misalign = (acc_mask == 4'b0000)
                   || ((acc_mask == MASK_H) && addr[0])
                   || ((acc_mask == MASK_W) && (addr[1:0] != 2'b00));

    // bus_ack in the final BUSY cycle takes priority over the timeout.
    assign timeout_hit = busy && !bus_ack && (cnt_q == CW'(TIMEOUT - 1));

    load_extend u_load_extend (
        .raw_i    (bus_rdata),
        .offset_i (addr_q[1:0]),
        .funct3_i (funct3_q),
        .result_o (load_val)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = misalign ? DONE : BUSY;
            BUSY:    if (bus_ack || timeout_hit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'd0;
            mask_q   <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
        end else begin
            cnt_q <= busy ? cnt_q + 1'b1 : '0;
            if (accept) begin
                we_q     <= memWE;
                funct3_q <= funct3;
                mask_q   <= acc_mask;
                addr_q   <= addr;
                wdata_q  <= wdata;
                err_q    <= misalign;
                if (misalign) rdata_q <= 32'd0;
            end
            if (busy && bus_ack) begin
                err_q   <= 1'b0;
                rdata_q <= we_q ? 32'd0 : load_val;
            end else if (timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= 32'd0;
            end
        end
    end

    // Outputs are zero outside their qualifying state so reset forces them low.
    always_comb begin
        stall     = busy || (accept && rst_n);
        done      = (state_q == DONE);
        err       = done && err_q;
        rdata     = rdata_q;
        bus_req   = busy;
        bus_we    = busy && we_q;
        bus_addr  = busy ? {addr_q[31:2], 2'b00} : 32'd0;
        bus_be    = busy ? (mask_q << addr_q[1:0]) : 4'd0;
        bus_wdata = busy ? (wdata_q << {addr_q[1:0], 3'b000}) : 32'd0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed scenarios for mem_access_unit built with TIMEOUT=4. Inputs change
// and outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, rwmem, memWE;
    logic [3:0]  byteena;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, done, err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .rwmem     (rwmem),
        .memWE     (memWE),
        .byteena   (byteena),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE, check the combinational stall, then cross the
    // accepting edge and withdraw the request.
    task automatic issue(input logic we, input logic [3:0] be, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input string name);
        req_valid = 1'b1; rwmem = 1'b1; memWE = we;
        byteena = be; funct3 = f3; addr = a; wdata = d;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL %s_accept_stall: got %b expected 1", name, stall); else pass_cnt++;
        tick();
        req_valid = 1'b0; rwmem = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; rwmem = 1'b1; memWE = 1'b0;
        byteena = 4'd0; funct3 = 3'b010; addr = 32'd0; wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        #3;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else pass_cnt++;
        total_cnt++; if ({bus_req, done, err, bus_we} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {bus_req, done, err, bus_we}); else pass_cnt++;
        total_cnt++; if ({rdata, bus_addr, bus_wdata, bus_be} !== 100'd0) $display("FAIL reset_data: got nonzero rdata=%h bus_addr=%h", rdata, bus_addr); else pass_cnt++;
        req_valid = 1'b0; rwmem = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lb();
        issue(1'b0, 4'b0000, 3'b000, 32'h0000_1003, 32'd0, "lb");
        total_cnt++; if (bus_req !== 1'b1) $display("FAIL lb_bus_req: got %b expected 1", bus_req); else pass_cnt++;
        total_cnt++; if (bus_addr !== 32'h0000_1000) $display("FAIL lb_bus_addr: got %h expected 00001000", bus_addr); else pass_cnt++;
        total_cnt++; if (bus_be !== 4'b1000) $display("FAIL lb_bus_be: got %b expected 1000", bus_be); else pass_cnt++;
        total_cnt++; if (bus_we !== 1'b0) $display("FAIL lb_bus_we: got %b expected 0", bus_we); else pass_cnt++;
        tick();
        total_cnt++; if ({bus_req, stall, bus_addr} !== {2'b11, 32'h0000_1000}) $display("FAIL lb_hold2: got req=%b stall=%b addr=%h", bus_req, stall, bus_addr); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL lb_early_done: got %b expected 0", done); else pass_cnt++;
        bus_ack = 1'b1; bus_rdata = 32'h8012_3456;
        tick();
        bus_ack = 1'b0; bus_rdata = 32'd0;
        total_cnt++; if ({done, err, stall, bus_req} !== 4'b1000) $display("FAIL lb_done: got done/err/stall/req=%b expected 1000", {done, err, stall, bus_req}); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata: got %h expected ffffff80", rdata); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL lb_done_pulse: got %b expected 0", done); else pass_cnt++;
        total_cnt++; if (rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata_hold: got %h expected ffffff80", rdata); else pass_cnt++;
    endtask

    task automatic test_misaligned();
        issue(1'b0, 4'b0000, 3'b010, 32'h0000_0006, 32'd0, "lw_mis");
        total_cnt++; if ({done, err, bus_req, stall} !== 4'b1100) $display("FAIL mis_done: got done/err/req/stall=%b expected 1100", {done, err, bus_req, stall}); else pass_cnt++;
        total_cnt++; if (rdata !== 32'd0) $display("FAIL mis_rdata: got %h expected 00000000", rdata); else pass_cnt++;
        tick();
        total_cnt++; if ({done, stall, bus_req} !== 3'b000) $display("FAIL mis_after: got done/stall/req=%b expected 000", {done, stall, bus_req}); else pass_cnt++;
    endtask

    task automatic test_lh_lhu();
        // LH at offset 2: upper halfword 0x8001 sign-extends.
        issue(1'b0, 4'b0000, 3'b001, 32'h0000_0012, 32'd0, "lh");
        total_cnt++; if (bus_be !== 4'b1100) $display("FAIL lh_bus_be: got %b expected 1100", bus_be); else pass_cnt++;
        bus_ack = 1'b1; bus_rdata = 32'h8001_7777;
        tick();
        bus_ack = 1'b0;
        total_cnt++; if ({done, rdata} !== {1'b1, 32'hFFFF_8001}) $display("FAIL lh_rdata: got done=%b rdata=%h expected 1 ffff8001", done, rdata); else pass_cnt++;
        tick();
        // LHU at offset 2 zero-extends the same pattern.
        issue(1'b0, 4'b0000, 3'b101, 32'h0000_0012, 32'd0, "lhu");
        bus_ack = 1'b1; bus_rdata = 32'h8001_7777;
        tick();
        bus_ack = 1'b0;
        total_cnt++; if ({done, rdata} !== {1'b1, 32'h0000_8001}) $display("FAIL lhu_rdata: got done=%b rdata=%h expected 1 00008001", done, rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_sh();
        issue(1'b1, 4'b0011, 3'b001, 32'h0000_2002, 32'h0000_BEEF, "sh");
        total_cnt++; if (bus_be !== 4'b1100) $display("FAIL sh_bus_be: got %b expected 1100", bus_be); else pass_cnt++;
        total_cnt++; if (bus_wdata !== 32'hBEEF_0000) $display("FAIL sh_bus_wdata: got %h expected beef0000", bus_wdata); else pass_cnt++;
        total_cnt++; if ({bus_we, bus_addr} !== {1'b1, 32'h0000_2000}) $display("FAIL sh_bus_we_addr: got we=%b addr=%h expected 1 00002000", bus_we, bus_addr); else pass_cnt++;
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        total_cnt++; if ({done, err, rdata} !== {2'b10, 32'd0}) $display("FAIL sh_done: got done=%b err=%b rdata=%h expected 1 0 00000000", done, err, rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        issue(1'b0, 4'b0000, 3'b101, 32'h0000_0004, 32'd0, "lhu_to");
        for (int c = 0; c < 4; c++) begin
            if (bus_req === 1'b1 && done === 1'b0) req_cycles++;
            // A second request while BUSY must not disturb the transaction.
            if (c == 1) begin
                req_valid = 1'b1; rwmem = 1'b1; memWE = 1'b1; byteena = 4'b1111;
                addr = 32'h0000_0100; wdata = 32'hDEAD_BEEF;
            end
            tick();
            if (c == 1) begin
                total_cnt++; if ({bus_addr, bus_we} !== {32'h0000_0004, 1'b0}) $display("FAIL busy_ignore_req: got addr=%h we=%b expected 00000004 0", bus_addr, bus_we); else pass_cnt++;
                req_valid = 1'b0; rwmem = 1'b0;
            end
        end
        total_cnt++; if (req_cycles != 4) $display("FAIL to_req_cycles: got %0d expected 4", req_cycles); else pass_cnt++;
        total_cnt++; if ({done, err, bus_req, rdata} !== {3'b110, 32'd0}) $display("FAIL to_done_err: got done=%b err=%b req=%b rdata=%h expected 1 1 0 0", done, err, bus_req, rdata); else pass_cnt++;
        tick();
        total_cnt++; if ({done, bus_req, stall} !== 3'b000) $display("FAIL to_after: got done/req/stall=%b expected 000", {done, bus_req, stall}); else pass_cnt++;
    endtask

    task automatic test_ack_at_timeout();
        issue(1'b0, 4'b0000, 3'b010, 32'h0000_0008, 32'd0, "lw_ackto");
        tick(); tick(); tick();
        total_cnt++; if (bus_req !== 1'b1) $display("FAIL ackto_req4: got %b expected 1", bus_req); else pass_cnt++;
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        tick();
        bus_ack = 1'b0;
        total_cnt++; if ({done, err, rdata} !== {2'b10, 32'h1234_5678}) $display("FAIL ackto_win: got done=%b err=%b rdata=%h expected 1 0 12345678", done, err, rdata); else pass_cnt++;
        tick();
    endtask

    task automatic test_rwmem0();
        req_valid = 1'b1; rwmem = 1'b0; memWE = 1'b0; funct3 = 3'b010; addr = 32'h40;
        #1;
        total_cnt++; if (stall !== 1'b0) $display("FAIL rwmem0_stall: got %b expected 0", stall); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++; if ({bus_req, done} !== 2'b00) $display("FAIL rwmem0_noop: got req/done=%b expected 00", {bus_req, done}); else pass_cnt++;
    endtask

    task automatic test_reset_mid_busy();
        int seen_done = 0;
        issue(1'b0, 4'b0000, 3'b010, 32'h0000_000C, 32'd0, "lw_rst");
        tick();
        #2 rst_n = 1'b0;
        #1;
        total_cnt++; if ({bus_req, stall, done} !== 3'b000) $display("FAIL rst_async: got req/stall/done=%b expected 000", {bus_req, stall, done}); else pass_cnt++;
        tick();
        rst_n = 1'b1;
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 3; c++) begin
            tick();
            bus_ack = 1'b0;
            if (done !== 1'b0 || bus_req !== 1'b0) seen_done++;
        end
        total_cnt++; if (seen_done != 0) $display("FAIL rst_late_ack: got %0d cycles with done/req expected 0", seen_done); else pass_cnt++;
        total_cnt++; if (rdata !== 32'd0) $display("FAIL rst_rdata: got %h expected 00000000", rdata); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_lb();
        test_misaligned();
        test_lh_lhu();
        test_sh();
        test_timeout();
        test_ack_at_timeout();
        test_rwmem0();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
